// File: rtl/difftest_event_pkg.sv
// difftest_event_pkg: shared redirect event record and width constants
package difftest_event_pkg;
  localparam int PC_W  = 64;
  localparam int ID_W  = 64;
  localparam int SEQ_W = 32;
  typedef struct packed {
    logic [7:0]       coreid;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  target_pc;
    logic [ID_W-1:0]  checkpoint_id;
    logic [SEQ_W-1:0] seq;
  } redirect_event_t;
endpackage

// File: rtl/difftest_event_fifo.sv
// difftest_event_fifo: multi-write, single-read FIFO of redirect events
module difftest_event_fifo
  import difftest_event_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [NUM_CH-1:0]        wr_en_i,
  input  redirect_event_t          wr_data_i [NUM_CH],
  input  logic                     pop_i,
  output redirect_event_t          rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  redirect_event_t mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, n_wr;
  logic [AW-1:0] woff [NUM_CH];
  // enabled ports land in consecutive slots, ordered by port index
  always_comb begin
    n_wr = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      woff[j] = wptr_q + AW'(n_wr);
      n_wr = n_wr + CW'(wr_en_i[j]);
    end
  end
  // storage, pointers and occupancy; flush only resets bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int j = 0; j < NUM_CH; j++)
        if (wr_en_i[j]) mem_q[woff[j]] <= wr_data_i[j];
      wptr_q  <= wptr_q + AW'(n_wr);
      rptr_q  <= rptr_q + AW'(pop_i);
      count_q <= count_q + n_wr - CW'(pop_i);
    end
  end
  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = count_q;
endmodule

// File: rtl/difftest_runahead_redirect_queue.sv
// difftest_runahead_redirect_queue: stamps, queues and checks multi-channel redirect events
module difftest_runahead_redirect_queue #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8,
  parameter int PC_W   = difftest_event_pkg::PC_W,
  parameter int ID_W   = difftest_event_pkg::ID_W,
  parameter int SEQ_W  = difftest_event_pkg::SEQ_W,
  parameter int OVF_W  = 16
) (
  input  logic                     io_clock,
  input  logic                     io_reset_n,
  input  logic [7:0]               io_coreid,
  input  logic                     io_flush,
  input  logic [NUM_CH-1:0]        io_in_valid,
  input  logic [NUM_CH*PC_W-1:0]   io_in_pc,
  input  logic [NUM_CH*PC_W-1:0]   io_in_target_pc,
  input  logic [NUM_CH*ID_W-1:0]   io_in_checkpoint_id,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [7:0]               io_out_coreid,
  output logic [PC_W-1:0]          io_out_pc,
  output logic [PC_W-1:0]          io_out_target_pc,
  output logic [ID_W-1:0]          io_out_checkpoint_id,
  output logic [SEQ_W-1:0]         io_out_seq,
  output logic [$clog2(DEPTH):0]   io_count,
  output logic                     io_full,
  output logic [OVF_W-1:0]         io_overflow_cnt,
  output logic                     io_order_err
);
  import difftest_event_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic [OVF_W:0]   ovf_sum;
  logic [ID_W-1:0]  last_q, last_d, id_c;
  logic             have_q, have_d, err_q, err_d, deq;
  logic [CW-1:0]    count;
  logic [CW:0]      free, acc;
  logic [2:0]       drop;
  logic [NUM_CH-1:0] wr_en;
  redirect_event_t  wr_data [NUM_CH];
  redirect_event_t  head;
  assign deq  = io_out_valid & io_out_ready;
  assign free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(deq);
  // accept the first `free` valid channels in order; stamp, order-check, count drops
  always_comb begin
    wr_en  = '0;
    acc    = '0;
    drop   = '0;
    last_d = last_q;
    have_d = have_q;
    err_d  = err_q;
    id_c   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_data[i] = '0;
      id_c = io_in_checkpoint_id[i*ID_W +: ID_W];
      if (io_in_valid[i] && !io_flush) begin
        if (acc < free) begin
          wr_en[i]   = 1'b1;
          wr_data[i] = '{coreid: io_coreid, pc: io_in_pc[i*PC_W +: PC_W],
                         target_pc: io_in_target_pc[i*PC_W +: PC_W],
                         checkpoint_id: id_c, seq: seq_q + SEQ_W'(acc)};
          err_d  = err_d | (have_d & (id_c <= last_d));
          last_d = id_c;
          have_d = 1'b1;
          acc    = acc + (CW+1)'(1);
        end else begin
          drop = drop + 3'd1;
        end
      end
    end
    seq_d   = seq_q + SEQ_W'(acc);
    ovf_sum = {1'b0, ovf_q} + (OVF_W+1)'(drop);
    ovf_d   = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
  end
  // sequence, overflow and ordering state survive flush
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      seq_q  <= '0;
      ovf_q  <= '0;
      last_q <= '0;
      have_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
      last_q <= last_d;
      have_q <= have_d;
      err_q  <= err_d;
    end
  end
  difftest_event_fifo #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) u_fifo (
    .clk       (io_clock),
    .rst_n     (io_reset_n),
    .flush_i   (io_flush),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .pop_i     (deq),
    .rd_data_o (head),
    .count_o   (count)
  );
  assign io_out_valid         = count != '0;
  assign io_out_coreid        = head.coreid;
  assign io_out_pc            = head.pc;
  assign io_out_target_pc     = head.target_pc;
  assign io_out_checkpoint_id = head.checkpoint_id;
  assign io_out_seq           = head.seq;
  assign io_count             = count;
  assign io_full              = count == CW'(DEPTH);
  assign io_overflow_cnt      = ovf_q;
  assign io_order_err         = err_q;
endmodule

// File: tb/tb_difftest_runahead_redirect_queue.sv
// tb_difftest_runahead_redirect_queue: directed self-checking bench for the redirect queue
module tb_difftest_runahead_redirect_queue;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 8;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   coreid;
  logic         flush;
  logic [1:0]   in_valid;
  logic [127:0] in_pc, in_tgt, in_id;
  logic         out_valid, out_ready;
  logic [7:0]   out_coreid;
  logic [63:0]  out_pc, out_tgt, out_id;
  logic [31:0]  out_seq;
  logic [3:0]   count;
  logic         full;
  logic [15:0]  ovf;
  logic         order_err;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  difftest_runahead_redirect_queue #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .io_clock(clk), .io_reset_n(rst_n), .io_coreid(coreid), .io_flush(flush),
    .io_in_valid(in_valid), .io_in_pc(in_pc), .io_in_target_pc(in_tgt),
    .io_in_checkpoint_id(in_id), .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_out_coreid(out_coreid), .io_out_pc(out_pc), .io_out_target_pc(out_tgt),
    .io_out_checkpoint_id(out_id), .io_out_seq(out_seq), .io_count(count),
    .io_full(full), .io_overflow_cnt(ovf), .io_order_err(order_err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic setch(input int c, input logic v, input logic [63:0] id);
    in_valid[c]          = v;
    in_pc[c*64 +: 64]    = 64'h1000 + id;
    in_tgt[c*64 +: 64]   = 64'h2000 + id;
    in_id[c*64 +: 64]    = id;
  endtask
  task automatic clear_in;
    in_valid = '0;
    in_pc    = '0;
    in_tgt   = '0;
    in_id    = '0;
  endtask
  task automatic do_reset;
    clear_in();
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    #2;
    rst_n     = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0; coreid = 8'h3A; flush = 1'b0; out_ready = 1'b0;
    clear_in();
    repeat (2) tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_order", 64'(order_err), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_seq", 64'(out_seq), 64'd0);
    rst_n = 1'b1;
    tick();
    setch(0, 1'b1, 64'd1);
    in_pc[63:0]  = 64'h8000_0000;
    in_tgt[63:0] = 64'h8000_0100;
    out_ready = 1'b1;
    tick();
    clear_in();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_pc", out_pc, 64'h8000_0000);
    chk("t1_tgt", out_tgt, 64'h8000_0100);
    chk("t1_id", out_id, 64'd1);
    chk("t1_seq", 64'(out_seq), 64'd0);
    chk("t1_coreid", 64'(out_coreid), 64'h3A);
    chk("t1_count1", 64'(count), 64'd1);
    tick();
    chk("t1_count0", 64'(count), 64'd0);
    chk("t1_valid0", 64'(out_valid), 64'd0);
    do_reset();
    tick();
    for (int c = 0; c < 5; c++) begin
      setch(0, 1'b1, 64'(2*c+1));
      setch(1, 1'b1, 64'(2*c+2));
      tick();
    end
    clear_in();
    chk("t2_count", 64'(count), 64'd8);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_ovf", 64'(ovf), 64'd2);
    chk("t2_head_id", out_id, 64'd1);
    chk("t2_order", 64'(order_err), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_drain_id", out_id, 64'(k+1));
      chk("t2_drain_seq", 64'(out_seq), 64'(k));
      chk("t2_drain_pc", out_pc, 64'h1000 + 64'(k+1));
      tick();
    end
    chk("t2_empty", 64'(count), 64'd0);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      setch(0, 1'b1, 64'(11+2*c));
      setch(1, 1'b1, 64'(12+2*c));
      tick();
    end
    chk("t3_full", 64'(full), 64'd1);
    out_ready = 1'b1;
    setch(0, 1'b1, 64'd19);
    setch(1, 1'b1, 64'd20);
    tick();
    clear_in();
    out_ready = 1'b0;
    chk("t3_count", 64'(count), 64'd8);
    chk("t3_ovf", 64'(ovf), 64'd3);
    chk("t3_head_id", out_id, 64'd12);
    chk("t3_head_seq", 64'(out_seq), 64'd9);
    chk("t3_order", 64'(order_err), 64'd0);
    do_reset();
    tick();
    setch(0, 1'b1, 64'd5);
    setch(1, 1'b1, 64'd5);
    tick();
    chk("t4_order_set", 64'(order_err), 64'd1);
    chk("t4_count", 64'(count), 64'd2);
    setch(0, 1'b1, 64'd6);
    setch(1, 1'b1, 64'd7);
    tick();
    chk("t4_order_sticky", 64'(order_err), 64'd1);
    chk("t4_count4", 64'(count), 64'd4);
    flush = 1'b1;
    setch(0, 1'b1, 64'd8);
    setch(1, 1'b0, 64'd0);
    tick();
    flush = 1'b0;
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_ovf", 64'(ovf), 64'd0);
    chk("t5_order", 64'(order_err), 64'd1);
    setch(0, 1'b1, 64'd9);
    tick();
    clear_in();
    chk("t5_count1", 64'(count), 64'd1);
    chk("t5_seq", 64'(out_seq), 64'd4);
    chk("t5_id", out_id, 64'd9);
    do_reset();
    tick();
    force dut.seq_q = 32'hFFFF_FFFF;
    #1;
    release dut.seq_q;
    setch(0, 1'b1, 64'd1);
    setch(1, 1'b1, 64'd2);
    tick();
    clear_in();
    chk("t6_count", 64'(count), 64'd2);
    chk("t6_seq_hi", 64'(out_seq), 64'hFFFF_FFFF);
    out_ready = 1'b1;
    tick();
    chk("t6_seq_wrap", 64'(out_seq), 64'd0);
    chk("t6_id", out_id, 64'd2);
    setch(0, 1'b1, 64'd3);
    setch(1, 1'b1, 64'd4);
    tick();
    chk("t6_burst", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", 64'(out_valid), 64'd0);
    chk("t6_arst_count", 64'(count), 64'd0);
    chk("t6_arst_pc", out_pc, 64'd0);
    chk("t6_arst_seq", 64'(out_seq), 64'd0);
    chk("t6_arst_full", 64'(full), 64'd0);
    chk("t6_arst_order", 64'(order_err), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
